// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_addsub_rca.sv
// Four-bit ripple-carry adder slice shared by every nibble pass.
module four_bit_RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c[0] = cin;
        s    = 4'd0;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract that reuses one 4-bit adder slice, LSB nibble first.
//   state | meaning
//   IDLE  | ready for operands
//   RUN   | one nibble per clock through the slice
//   DONE  | result and flags held until out_ready
module nibble_serial_addsub
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic                s_cout;

    four_bit_RCA u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (s_cout)
    );

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
                b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[NIBBLE_W*i +: NIBBLE_W] = s_nib;
                    end
                end
                carry_d = s_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = s_cout;
                    ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (s_nib[NIBBLE_W-1] ^ a_q[WIDTH-1]);
                    zero_d  = (sum_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
